bit_serial_alu_seq: RTL and testbench
=====================================

BIT_SERIAL_ALU_SEQ -- requirements
Module: bit_serial_alu_seq

Interface
REQ-001 SHALL have parameter: WIDTH, default 32, operand/result width in bits (legal range 2..64).
REQ-002 SHALL have port: clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port: reset_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port: in_valid  input  1  operation request present.
REQ-005 SHALL have port: in_ready  output  1  request accepted on any edge where in_valid & in_ready.
REQ-006 SHALL have port: command  input  3  opcode: 0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 NOR, 7 OR.
REQ-007 SHALL have port: a  input  WIDTH  first operand, 2's complement.
REQ-008 SHALL have port: b  input  WIDTH  second operand, 2's complement.
REQ-009 SHALL have port: out_valid  output  1  result fields valid.
REQ-010 SHALL have port: out_ready  input  1  consumer takes result on any edge where out_valid & out_ready.
REQ-011 SHALL have port: result  output  WIDTH  operation result.
REQ-012 SHALL have port: carryout  output  1  carry out of MSB (ADD/SUB only, else 0).
REQ-013 SHALL have port: overflow  output  1  signed overflow (ADD/SUB only, else 0).
REQ-014 SHALL have port: zero  output  1  result == 0.
REQ-015 SHALL have port: busy  output  1  state is RUN.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE, with exactly one 1-bit ALU slice evaluated per cycle.
REQ-017 in_ready SHALL = (state==IDLE) | (state==DONE & out_ready), combinationally.
REQ-018 On accept, SHALL latch a, b, command; set bit index to 0; set carry register to 1 for SUB/SLT, else 0; go to RUN.
REQ-019 In RUN, each edge SHALL process bit i: slice result into result register bit i, carry register updated (ADD/SUB/SLT), index incremented.
REQ-020 For SUB/SLT the slice SHALL use b[i] XOR 1; carry-in of bit 0 SHALL be 1.
REQ-021 Logic ops per bit: XOR a^b, AND a&b, NAND ~(a&b), NOR ~(a|b), OR a|b; carry register unused.
REQ-022 On the edge processing bit WIDTH-1, state SHALL go to DONE and out_valid SHALL rise; latency SHALL be WIDTH+1 edges from accept to out_valid visible.
REQ-023 overflow SHALL = carry into MSB XOR carry out of MSB, for ADD/SUB only.
REQ-024 SLT SHALL yield result = {WIDTH-1 zeros, sign(a-b) XOR overflow(a-b)}, with carryout=0 and overflow=0.
REQ-025 zero SHALL be computed from the final result register, valid with out_valid.
REQ-026 In DONE, result/carryout/overflow/zero/out_valid SHALL hold stable until the handshake.
REQ-027 On DONE handshake without a new accept, SHALL go to IDLE and drop out_valid.
REQ-028 On DONE handshake with in_valid=1, SHALL accept the new request on the same edge and go to RUN (back-to-back).
REQ-029 In RUN, in_valid SHALL be ignored; a, b, command changes SHALL NOT affect the operation in flight.
REQ-030 result, carryout, overflow, zero SHALL be 0 in IDLE and RUN (internal result register not exposed until DONE).

Reset
REQ-031 reset_n=0 at a rising edge SHALL force IDLE, index 0, carry 0, result register 0, out_valid 0, busy 0, regardless of state; operation in flight SHALL be discarded.
REQ-032 reset_n SHALL take priority over any handshake on the same edge; in_ready SHALL be 1 on the first cycle after reset is released.

Verification
REQ-033 ADD a=0x7FFFFFFF, b=0x00000001 -> out_valid 33 edges after accept; result 0x80000000, overflow 1, carryout 0, zero 0.
REQ-034 SUB a=5, b=5 -> result 0, zero 1, carryout 1, overflow 0; SUB a=0x80000000, b=1 -> result 0x7FFFFFFF, overflow 1.
REQ-035 SLT a=0x80000000, b=1 -> result 1, overflow 0; SLT a=1, b=0xFFFFFFFF -> result 0; NOR a=0, b=0 -> result 0xFFFFFFFF, carryout 0.
REQ-036 Backpressure: out_ready held 0 for 5 cycles in DONE -> outputs constant and in_ready 0; then out_ready=1 with in_valid=1 (XOR 0xF0F0F0F0,0xFFFF0000) -> accepted same edge, busy 1 next cycle, result 0x0F0FF0F0 after 33 edges.
REQ-037 Change a/b/command and pulse in_valid during RUN -> original operation result unaffected, no extra accept.
REQ-038 Assert reset_n=0 for one edge at bit 10 of RUN -> next cycle IDLE, busy 0, out_valid 0, result 0, in_ready 1; a new ADD completes correctly.

Source files
------------

// File: rtl/bit_serial_alu_seq.sv
// Bit-serial ALU: one 1-bit slice per clock, valid/ready on both sides.
// Result fields are exposed only in DONE and held until the consumer takes them.
module bit_serial_alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       command,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow,
  output logic             zero,
  output logic             busy
);

  localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_SLT  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_NAND = 3'd5;
  localparam logic [2:0] OP_NOR  = 3'd6;
  localparam logic [2:0] OP_OR   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [IW-1:0]    idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       cmd_q;
  logic [WIDTH-1:0] res_q;
  logic             co_q;
  logic             ov_q;
  logic             out_valid_q;

  logic             accept;
  logic             sub_w;
  logic             ai;
  logic             bi;
  logic             sum;
  logic             cnx;
  logic             bit_w;
  logic             last;
  logic [WIDTH-1:0] res_d;

  assign in_ready = (state_q == S_IDLE) |
                    ((state_q == S_DONE) & out_ready);
  assign accept   = in_valid & in_ready;

  assign sub_w = (cmd_q == OP_SUB) | (cmd_q == OP_SLT);
  assign ai    = a_q[idx_q];
  assign bi    = b_q[idx_q] ^ sub_w;
  assign sum   = ai ^ bi ^ carry_q;
  assign cnx   = (ai & bi) | (carry_q & (ai ^ bi));
  assign last  = (idx_q == LAST);

  always_comb begin
    bit_w = 1'b0;
    unique case (cmd_q)
      OP_ADD, OP_SUB: bit_w = sum;
      OP_SLT:         bit_w = 1'b0;
      OP_XOR:         bit_w = a_q[idx_q] ^ b_q[idx_q];
      OP_AND:         bit_w = a_q[idx_q] & b_q[idx_q];
      OP_NAND:        bit_w = ~(a_q[idx_q] & b_q[idx_q]);
      OP_NOR:         bit_w = ~(a_q[idx_q] | b_q[idx_q]);
      OP_OR:          bit_w = a_q[idx_q] | b_q[idx_q];
    endcase
  end

  // SLT: less-than is sign(a-b) XOR overflow(a-b), known only at the MSB
  always_comb begin
    res_d        = res_q;
    res_d[idx_q] = bit_w;
    if (last && cmd_q == OP_SLT) begin
      res_d    = '0;
      res_d[0] = sum ^ (carry_q ^ cnx);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      cmd_q       <= OP_ADD;
      res_q       <= '0;
      co_q        <= 1'b0;
      ov_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_RUN: begin
          res_q   <= res_d;
          carry_q <= cnx;
          idx_q   <= idx_q + 1'b1;
          if (last) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
            if (cmd_q == OP_ADD || cmd_q == OP_SUB) begin
              co_q <= cnx;
              ov_q <= carry_q ^ cnx;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      if (accept) begin
        state_q     <= S_RUN;
        out_valid_q <= 1'b0;
        a_q         <= a;
        b_q         <= b;
        cmd_q       <= command;
        idx_q       <= '0;
        carry_q     <= (command == OP_SUB) |
                       (command == OP_SLT);
        res_q       <= '0;
        co_q        <= 1'b0;
        ov_q        <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign busy      = (state_q == S_RUN);
  assign result    = (state_q == S_DONE) ? res_q : '0;
  assign carryout  = (state_q == S_DONE) & co_q;
  assign overflow  = (state_q == S_DONE) & ov_q;
  assign zero      = (state_q == S_DONE) & (res_q == '0);

endmodule

// File: tb/tb_bit_serial_alu_seq.sv
// Bench for bit_serial_alu_seq: directed corner cases plus random ops
// checked against an arithmetic reference model.
module tb_bit_serial_alu_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   command;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carryout;
  logic         overflow;
  logic         zero;
  logic         busy;

  int tests = 0;
  int fails = 0;

  bit_serial_alu_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .command  (command),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .carryout (carryout),
    .overflow (overflow),
    .zero     (zero),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [2:0] c, input logic [W-1:0] x,
                       input logic [W-1:0] y, output logic [W-1:0] r,
                       output logic co, output logic ov);
    logic [W:0] s;
    r = '0; co = 1'b0; ov = 1'b0;
    case (c)
      3'd0: begin
        s  = {1'b0, x} + {1'b0, y};
        r  = s[W-1:0]; co = s[W];
        ov = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
      end
      3'd1: begin
        s  = {1'b0, x} + {1'b0, ~y} + 1;
        r  = s[W-1:0]; co = s[W];
        ov = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
      end
      3'd2: r = x ^ y;
      3'd3: r = ($signed(x) < $signed(y)) ? 1 : 0;
      3'd4: r = x & y;
      3'd5: r = ~(x & y);
      3'd6: r = ~(x | y);
      default: r = x | y;
    endcase
  endtask

  task automatic start(input logic [2:0] c, input logic [W-1:0] x,
                       input logic [W-1:0] y);
    @(negedge clk);
    in_valid = 1'b1; command = c; a = x; b = y;
    chk("accept_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_ov(output int n);
    n = 0;
    while (n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (out_valid) break;
    end
  endtask

  task automatic wait_done();
    int n;
    @(negedge clk);
    chk("run_busy", busy, 1);
    chk("run_result_hidden", result, 0);
    chk("run_no_valid", out_valid, 0);
    wait_ov(n);
    chk("latency_edges_after_accept", n + 1, W + 1);
  endtask

  task automatic check_out(input logic [2:0] c, input logic [W-1:0] x,
                           input logic [W-1:0] y);
    logic [W-1:0] r;
    logic co, ov;
    model(c, x, y, r, co, ov);
    chk($sformatf("result op%0d", c), result, r);
    chk($sformatf("carryout op%0d", c), carryout, co);
    chk($sformatf("overflow op%0d", c), overflow, ov);
    chk($sformatf("zero op%0d", c), zero, r == '0);
    chk("done_not_busy", busy, 0);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("after_take_valid", out_valid, 0);
    chk("after_take_ready", in_ready, 1);
    chk("after_take_result", result, 0);
  endtask

  task automatic op(input logic [2:0] c, input logic [W-1:0] x,
                    input logic [W-1:0] y);
    start(c, x, y);
    wait_done();
    check_out(c, x, y);
    consume();
  endtask

  initial begin
    logic [W-1:0] r0;
    logic [2:0]   f0;
    int           n;

    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    command = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);

    op(3'd0, 32'h7FFF_FFFF, 32'h0000_0001);
    op(3'd1, 32'd5, 32'd5);
    op(3'd1, 32'h8000_0000, 32'd1);
    op(3'd3, 32'h8000_0000, 32'd1);
    op(3'd3, 32'd1, 32'hFFFF_FFFF);
    op(3'd6, 32'd0, 32'd0);
    op(3'd0, 32'hFFFF_FFFF, 32'h0000_0001);

    // backpressure, then back-to-back accept on the handshake edge
    start(3'd4, 32'hDEAD_BEEF, 32'h0FF0_F00F);
    wait_done();
    r0 = result;
    f0 = {carryout, overflow, zero};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_result", result, r0);
      chk("bp_flags", {carryout, overflow, zero}, f0);
      chk("bp_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1; in_valid = 1'b1;
    command = 3'd2; a = 32'hF0F0_F0F0; b = 32'hFFFF_0000;
    #1 chk("b2b_in_ready", in_ready, 1);
    @(posedge clk);
    #1 begin in_valid = 1'b0; out_ready = 1'b0; end
    wait_done();
    chk("b2b_xor", result, 32'h0F0F_F0F0);
    check_out(3'd2, 32'hF0F0_F0F0, 32'hFFFF_0000);
    consume();

    // input churn while running must not disturb the operation
    start(3'd1, 32'h1234_5678, 32'h0765_4321);
    repeat (5) @(negedge clk);
    in_valid = 1'b1; command = 3'd7; a = 32'hFFFF_FFFF; b = 32'h0;
    @(negedge clk);
    in_valid = 1'b0;
    wait_ov(n);
    chk("churn_done", out_valid, 1);
    check_out(3'd1, 32'h1234_5678, 32'h0765_4321);
    consume();
    @(negedge clk);
    chk("churn_no_extra_accept", busy, 0);

    // reset in the middle of a run
    start(3'd0, 32'hAAAA_AAAA, 32'h5555_5555);
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_result", result, 0);
    chk("midrst_in_ready", in_ready, 1);
    op(3'd0, 32'h0000_FFFF, 32'h0000_0001);

    for (int i = 0; i < 24; i++)
      op(3'($urandom_range(0, 7)), $urandom, $urandom);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
